// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the memory arbiter: FSM encoding, block geometry and grant ids.
package mem_arbiter_pkg;

  localparam int BEATS         = 8;
  localparam int BEAT_W        = $clog2(BEATS);
  localparam int WORD_OFFSET_W = 4;
  localparam int CNT_W         = 4;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  // Byte offset of a word inside the block: word index times the 2-byte stride.
  function automatic logic [WORD_OFFSET_W-1:0] beat_offset(input logic [BEAT_W-1:0] beat);
    return {beat, 1'b0};
  endfunction

endpackage

// File: rtl/mem_arbiter_beat_counter.sv
// Small beat counter with synchronous clear (priority) and increment.
module mem_arbiter_beat_counter
  import mem_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I/D cache block fills and D-cache write-through stores onto one
// pipelined memory port; returning beats are steered to the granted cache.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_miss_req,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss_req,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic              d_wr_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_enable,
  output logic              mem_wr,
  input  logic              mem_data_valid,
  output logic              i_fill_valid,
  output logic              d_fill_valid,
  output logic [BEAT_W-1:0] fill_beat,
  output logic              i_fill_done,
  output logic              d_fill_done,
  output logic              i_stall,
  output logic              d_stall
);

  localparam int BLK_W = ADDR_W - WORD_OFFSET_W;

  logic [0:0]       state_reg, state_next;
  logic             grant_reg, grant_next;
  logic             last_grant_reg, last_grant_next;
  logic [BLK_W-1:0] blk_addr_reg, blk_addr_next;

  logic             in_fill, issuing, last_beat;
  logic             cnt_clr;
  logic [1:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_val [2];
  logic [CNT_W-1:0] issue_cnt, recv_cnt;
  logic             pick_d;
  logic             unused_addr_bits;

  assign issue_cnt = cnt_val[0];
  assign recv_cnt  = cnt_val[1];

  assign in_fill   = (state_reg == ST_FILL);
  assign issuing   = in_fill && (issue_cnt < CNT_W'(BEATS));
  assign last_beat = in_fill && mem_data_valid && (recv_cnt == CNT_W'(BEATS - 1));

  // Both counters sit at zero outside a fill and are wiped as the last beat lands.
  assign cnt_clr    = !in_fill || last_beat;
  assign cnt_inc[0] = issuing;
  assign cnt_inc[1] = in_fill && mem_data_valid;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      mem_arbiter_beat_counter u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (cnt_inc[gi]),
        .count (cnt_val[gi])
      );
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    blk_addr_next   = blk_addr_reg;
    pick_d          = 1'b0;
    mem_enable      = 1'b0;
    mem_wr          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    d_wr_ack        = 1'b0;

    if (!in_fill) begin
      if (d_wr_req) begin
        // Stores own any idle cycle; pending misses wait one more cycle.
        mem_enable = 1'b1;
        mem_wr     = 1'b1;
        mem_addr   = d_wr_addr;
        mem_wdata  = d_wr_data;
        d_wr_ack   = 1'b1;
      end else if (i_miss_req || d_miss_req) begin
        if (i_miss_req && d_miss_req) begin
          pick_d = (last_grant_reg == GRANT_I);
        end else begin
          pick_d = d_miss_req;
        end
        grant_next    = pick_d ? GRANT_D : GRANT_I;
        blk_addr_next = pick_d ? d_miss_addr[ADDR_W-1:WORD_OFFSET_W]
                               : i_miss_addr[ADDR_W-1:WORD_OFFSET_W];
        state_next    = ST_FILL;
      end
    end else begin
      if (issuing) begin
        mem_enable = 1'b1;
        mem_addr   = {blk_addr_reg, beat_offset(issue_cnt[BEAT_W-1:0])};
      end
      if (last_beat) begin
        state_next      = ST_IDLE;
        last_grant_next = grant_reg;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      grant_reg      <= GRANT_I;
      last_grant_reg <= GRANT_I;
      blk_addr_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      blk_addr_reg   <= blk_addr_next;
    end
  end

  assign i_fill_valid = cnt_inc[1] && (grant_reg == GRANT_I);
  assign d_fill_valid = cnt_inc[1] && (grant_reg == GRANT_D);
  assign i_fill_done  = last_beat && (grant_reg == GRANT_I);
  assign d_fill_done  = last_beat && (grant_reg == GRANT_D);
  assign fill_beat    = recv_cnt[BEAT_W-1:0];

  assign i_stall = i_miss_req && !i_fill_done;
  assign d_stall = (d_miss_req && !d_fill_done) || (d_wr_req && !d_wr_ack);

  // The word offset inside a block is regenerated from the beat counter.
  assign unused_addr_bits = ^{i_miss_addr[WORD_OFFSET_W-1:0], d_miss_addr[WORD_OFFSET_W-1:0]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic, all checked
// cycle by cycle against a transaction-level model with a fixed-latency memory.
module tb_mem_arbiter;

  localparam int BEATS = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_miss_req, d_miss_req, d_wr_req;
  logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
  logic        d_wr_ack, mem_enable, mem_wr, mem_data_valid;
  logic [15:0] mem_addr, mem_wdata;
  logic        i_fill_valid, d_fill_valid, i_fill_done, d_fill_done, i_stall, d_stall;
  logic [2:0]  fill_beat;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .i_miss_req     (i_miss_req),
    .i_miss_addr    (i_miss_addr),
    .d_miss_req     (d_miss_req),
    .d_miss_addr    (d_miss_addr),
    .d_wr_req       (d_wr_req),
    .d_wr_addr      (d_wr_addr),
    .d_wr_data      (d_wr_data),
    .d_wr_ack       (d_wr_ack),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_enable     (mem_enable),
    .mem_wr         (mem_wr),
    .mem_data_valid (mem_data_valid),
    .i_fill_valid   (i_fill_valid),
    .d_fill_valid   (d_fill_valid),
    .fill_beat      (fill_beat),
    .i_fill_done    (i_fill_done),
    .d_fill_done    (d_fill_done),
    .i_stall        (i_stall),
    .d_stall        (d_stall)
  );

  int n_checks = 0;
  int n_errs   = 0;

  // Transaction-level model: which cache owns the memory, block base, beats issued/received.
  bit          m_busy, m_who, m_last_d;
  logic [15:0] m_base;
  int          m_issued, m_recvd;

  logic        e_en, e_wr, e_ack, e_iv, e_dv, e_idone, e_ddone;
  logic [15:0] e_addr, e_wdata;

  int          cyc = 0;
  int          lat = 4;
  int          rq[$];
  bit          stray = 0;
  bit          allow_new = 0;

  logic [15:0] iss_q[$];
  logic [31:0] wr_q[$];
  int          ivalid_n, dvalid_n, last_ack_cyc, last_idone_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy   = 0;
    m_who    = 0;
    m_last_d = 0;
    m_base   = '0;
    m_issued = 0;
    m_recvd  = 0;
  endtask

  task automatic clear_log();
    iss_q.delete();
    wr_q.delete();
    ivalid_n       = 0;
    dvalid_n       = 0;
    last_ack_cyc   = -1;
    last_idone_cyc = -1;
  endtask

  // One clock cycle: drive memory return, check at negedge, advance model at posedge,
  // then let the requesters react (drop on done/ack, optionally raise new requests).
  task automatic step();
    mem_data_valid = stray || (rq.size() > 0 && rq[0] == cyc);
    @(negedge clk);
    if (rst) model_reset();

    e_en = 0; e_wr = 0; e_ack = 0; e_iv = 0; e_dv = 0; e_idone = 0; e_ddone = 0;
    e_addr = '0; e_wdata = '0;
    if (!m_busy) begin
      if (d_wr_req) begin
        e_en = 1; e_wr = 1; e_ack = 1; e_addr = d_wr_addr; e_wdata = d_wr_data;
      end
    end else begin
      if (m_issued < BEATS) begin
        e_en   = 1;
        e_addr = m_base + 16'(2 * m_issued);
      end
      if (mem_data_valid) begin
        e_iv    = !m_who;
        e_dv    = m_who;
        e_idone = (m_recvd == BEATS - 1) && !m_who;
        e_ddone = (m_recvd == BEATS - 1) && m_who;
      end
    end

    chk("mem_enable", mem_enable, e_en);
    chk("d_wr_ack", d_wr_ack, e_ack);
    chk("i_fill_valid", i_fill_valid, e_iv);
    chk("d_fill_valid", d_fill_valid, e_dv);
    chk("i_fill_done", i_fill_done, e_idone);
    chk("d_fill_done", d_fill_done, e_ddone);
    chk("fill_beat", fill_beat, 32'(m_recvd % BEATS));
    chk("i_stall", i_stall, i_miss_req && !e_idone);
    chk("d_stall", d_stall, (d_miss_req && !e_ddone) || (d_wr_req && !e_ack));
    if (e_en) begin
      chk("mem_wr", mem_wr, e_wr);
      chk("mem_addr", mem_addr, e_addr);
    end
    if (e_wr) chk("mem_wdata", mem_wdata, e_wdata);

    if (mem_enable && !mem_wr) iss_q.push_back(mem_addr);
    if (mem_enable && mem_wr) wr_q.push_back({mem_addr, mem_wdata});
    if (i_fill_valid) ivalid_n++;
    if (d_fill_valid) dvalid_n++;
    if (d_wr_ack) last_ack_cyc = cyc;
    if (i_fill_done) last_idone_cyc = cyc;

    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (!m_busy) begin
      if (!d_wr_req && (i_miss_req || d_miss_req)) begin
        if (i_miss_req && d_miss_req) m_who = !m_last_d;
        else m_who = d_miss_req;
        m_base   = m_who ? {d_miss_addr[15:4], 4'h0} : {i_miss_addr[15:4], 4'h0};
        m_busy   = 1;
        m_issued = 0;
        m_recvd  = 0;
      end
    end else begin
      if (m_issued < BEATS) m_issued++;
      if (mem_data_valid) begin
        if (m_recvd == BEATS - 1) begin
          m_busy   = 0;
          m_last_d = m_who;
          m_recvd  = 0;
        end else begin
          m_recvd++;
        end
      end
    end
    if (e_en && !e_wr) rq.push_back(cyc + lat);
    if (rq.size() > 0 && rq[0] == cyc) void'(rq.pop_front());
    cyc++;
    #1;
    stray = 0;

    if (!rst) begin
      if (i_miss_req && e_idone) i_miss_req = 0;
      else if (!i_miss_req && allow_new && $urandom_range(0, 5) == 0) begin
        i_miss_req  = 1;
        i_miss_addr = 16'($urandom);
      end
      if (d_miss_req && e_ddone) d_miss_req = 0;
      else if (!d_miss_req && allow_new && $urandom_range(0, 5) == 0) begin
        d_miss_req  = 1;
        d_miss_addr = 16'($urandom);
      end
      if (d_wr_req && e_ack) d_wr_req = 0;
      else if (!d_wr_req && allow_new && $urandom_range(0, 9) == 0) begin
        d_wr_req  = 1;
        d_wr_addr = 16'($urandom);
        d_wr_data = 16'($urandom);
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((m_busy || i_miss_req || d_miss_req || d_wr_req || rq.size() > 0) && k < budget) begin
      step();
      k++;
    end
    n_checks++;
    if (k >= budget) begin
      n_errs++;
      $display("FAIL wait_idle: no return to idle within %0d cycles (cycle %0d)", budget, cyc);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    i_miss_req = 1; i_miss_addr = 16'h1234;
    d_miss_req = 0; d_miss_addr = '0;
    d_wr_req = 0; d_wr_addr = '0; d_wr_data = '0;
    mem_data_valid = 0;
    model_reset();
    clear_log();
    @(posedge clk);
    #1;
    chk("rst_mem_enable", mem_enable, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_fill_beat", fill_beat, 0);
    chk("rst_i_stall", i_stall, 1);
    step();
    rst = 0;

    // Single I fill, latency 4.
    lat = 4;
    clear_log();
    wait_idle(100);
    chk("t1_issue_count", iss_q.size(), 8);
    if (iss_q.size() == 8) begin
      chk("t1_first_addr", iss_q[0], 16'h1230);
      chk("t1_last_addr", iss_q[7], 16'h123E);
    end
    chk("t1_i_beats", ivalid_n, 8);

    // Simultaneous misses: D wins the first tie, then I, and the next tie goes to D.
    clear_log();
    i_miss_req = 1; i_miss_addr = 16'h5550;
    d_miss_req = 1; d_miss_addr = 16'hA004;
    wait_idle(200);
    chk("t2_issue_count", iss_q.size(), 16);
    if (iss_q.size() == 16) begin
      chk("t2_d_first", iss_q[0], 16'hA000);
      chk("t2_d_last", iss_q[7], 16'hA00E);
      chk("t2_i_first", iss_q[8], 16'h5550);
    end
    clear_log();
    i_miss_req = 1; i_miss_addr = 16'h6660;
    d_miss_req = 1; d_miss_addr = 16'hB00A;
    wait_idle(200);
    if (iss_q.size() > 0) chk("t2_tie2_first", iss_q[0], 16'hB000);
    else chk("t2_tie2_count", iss_q.size(), 16);

    // Write and miss in the same idle cycle: write goes first.
    clear_log();
    d_wr_req = 1; d_wr_addr = 16'h0040; d_wr_data = 16'hBEEF;
    i_miss_req = 1; i_miss_addr = 16'h2226;
    wait_idle(100);
    chk("t3_writes", wr_q.size(), 1);
    if (wr_q.size() > 0) chk("t3_write", wr_q[0], 32'h0040BEEF);
    if (iss_q.size() > 0) chk("t3_fill_first", iss_q[0], 16'h2220);
    else chk("t3_fill_count", iss_q.size(), 8);

    // Write raised during an I fill is held until the fill completes.
    clear_log();
    i_miss_req = 1; i_miss_addr = 16'h3330;
    repeat (3) step();
    d_wr_req = 1; d_wr_addr = 16'h0080; d_wr_data = 16'h1357;
    wait_idle(100);
    chk("t4_writes", wr_q.size(), 1);
    if (wr_q.size() > 0) chk("t4_write", wr_q[0], 32'h00801357);
    chk("t4_ack_after_done", last_ack_cyc, last_idone_cyc + 1);

    // Stray beat while idle.
    clear_log();
    stray = 1;
    step();
    chk("t5_no_valid", ivalid_n + dvalid_n, 0);
    chk("t5_fill_beat", fill_beat, 0);

    // Reset after 3 returned beats; late beats are ignored, then a fresh fill.
    clear_log();
    lat = 4;
    i_miss_req = 1; i_miss_addr = 16'h4440;
    for (int k = 0; k < 60 && !(m_busy && m_recvd == 3); k++) step();
    chk("t6_three_beats", ivalid_n, 3);
    rst = 1;
    i_miss_req = 0;
    step();
    chk("t6_rst_enable", mem_enable, 0);
    chk("t6_rst_beat", fill_beat, 0);
    rst = 0;
    clear_log();
    wait_idle(50);
    chk("t6_late_ignored", ivalid_n + dvalid_n, 0);
    clear_log();
    d_miss_req = 1; d_miss_addr = 16'h7775;
    wait_idle(100);
    chk("t6_d_beats", dvalid_n, 8);
    if (iss_q.size() > 0) chk("t6_first_addr", iss_q[0], 16'h7770);
    else chk("t6_issue_count", iss_q.size(), 8);

    // Randomized traffic at a few memory latencies.
    for (int ph = 0; ph < 3; ph++) begin
      lat = $urandom_range(1, 6);
      allow_new = 1;
      repeat (800) step();
      allow_new = 0;
      wait_idle(400);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits between the I-cache and D-cache fill FSMs and the single pipelined main memory.
- Grants one block fill at a time and generates the 8 consecutive word addresses for the memory pipeline.
- Routes returning memory_data_valid beats back to the granted cache with a beat index.
- Slots D-cache write-through stores into idle memory cycles.

Parameters:
- ADDR_W, 16, address width in bits.
- DATA_W, 16, data word width in bits.
- BEATS, 8, words per cache block. Must be a power of 2. Word stride is 2 bytes.

Ports:
- clk  in  1  system clock
- rst  in  1  reset. Decided: single clock; reset is asynchronous and active-high.
- i_miss_req  in  1  I-cache fill request; level, held until i_fill_done
- i_miss_addr  in  ADDR_W  I-cache missing address
- d_miss_req  in  1  D-cache fill request; level, held until d_fill_done
- d_miss_addr  in  ADDR_W  D-cache missing address
- d_wr_req  in  1  D-cache write-through request; level, held until d_wr_ack
- d_wr_addr  in  ADDR_W  write address
- d_wr_data  in  DATA_W  write data
- d_wr_ack  out  1  1-cycle pulse: write issued to memory this cycle
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_enable  out  1  memory access strobe
- mem_wr  out  1  memory write (valid only with mem_enable)
- mem_data_valid  in  1  memory read beat returning
- i_fill_valid  out  1  = mem_data_valid while the I-cache holds the grant
- d_fill_valid  out  1  = mem_data_valid while the D-cache holds the grant
- fill_beat  out  log2(BEATS)  index of the returning beat (receive count)
- i_fill_done  out  1  1-cycle pulse with the last I-cache beat
- d_fill_done  out  1  1-cycle pulse with the last D-cache beat
- i_stall  out  1  i_miss_req & not(i_fill_done)
- d_stall  out  1  (d_miss_req & not d_fill_done) | (d_wr_req & not d_wr_ack)

Behaviour:
- States: IDLE, FILL. Registers:
  - state
  - grant (0 = I, 1 = D)
  - last_grant
  - blk_addr (upper ADDR_W-4 bits of the latched miss address)
  - issue_cnt, 0..BEATS
  - recv_cnt, 0..BEATS-1
- Reset values: state=IDLE, both counters 0, grant=0, last_grant=0 (so the first tie goes to D), blk_addr=0. All outputs 0 except combinational stalls, which follow their inputs.
- IDLE, evaluated in this priority order:
  - d_wr_req: mem_enable=1, mem_wr=1, mem_addr=d_wr_addr, mem_wdata=d_wr_data, d_wr_ack=1. State stays IDLE. Misses wait one cycle.
  - Else, one miss pending: latch that requester's address into blk_addr, set grant, go to FILL. No memory access this cycle.
  - Else, both misses pending: round-robin. Grant the opposite of last_grant.
- FILL, issue side:
  - While issue_cnt < BEATS: mem_enable=1, mem_wr=0, mem_addr={blk_addr, issue_cnt[2:0], 1'b0}, then issue_cnt++.
  - First address is issued in the cycle after entry. Addresses go out on 8 consecutive cycles with no gaps.
- FILL, receive side:
  - Each mem_data_valid raises the granted fill_valid with fill_beat=recv_cnt, then recv_cnt++.
  - Beats may return while issue is still in progress; both counters run concurrently.
- FILL, completion:
  - When mem_data_valid & recv_cnt==BEATS-1: pulse the granted fill_done, set last_grant=grant, clear both counters, go to IDLE.
  - The next grant or write can start the following cycle.
- d_wr_req during FILL is not acked; it is held until IDLE.
- mem_data_valid in IDLE is ignored. No fill_valid and no counter change.
- Miss request dropped mid-FILL (illegal): the fill still completes. No abort.
- Async rst mid-FILL: immediately IDLE, counters 0. In-flight returns after reset are ignored.
- Address arithmetic: beat offset is the low 4 bits {beat,0}. The miss address low nibble is discarded.

Decomposition:
- Shared package:
  - state encoding (IDLE/FILL)
  - BEATS
  - WORD_OFFSET_W=4
  - GRANT_I/GRANT_D constants
- One natural sub-module: beat_counter. A 4-bit count register with clear and increment, instantiated twice (issue and receive).

Test Plan:
- I miss at addr 0x1234, memory latency 4 -> mem_addr 0x1230, 0x1232, ... 0x123E on 8 consecutive cycles. i_fill_valid on 8 beats with fill_beat 0..7. i_fill_done coincides with beat 7. Back in IDLE next cycle.
- i_miss_req and d_miss_req rise together after reset -> D granted first (addr 0xA000..0xA00E). I granted in the cycle after d_fill_done. Next tie goes to D again.
- d_wr_req (0x0040, 0xBEEF) and i_miss_req in same IDLE cycle -> write issued with d_wr_ack=1 and mem_wr=1. I fill starts the following cycle.
- d_wr_req asserted during I fill -> no ack, d_stall=1 until IDLE. Then one write cycle.
- Stray mem_data_valid in IDLE -> no fill_valid, fill_beat stays 0, no state change.
- rst pulse after 3 beats returned -> IDLE, counters 0. Later valid beats ignored. A new miss then issues from beat 0.
